// File: rtl/cpa_pkg.sv
// Shared types and helpers for the pipelined carry-propagate adder.
// Stage data fields are WIDTH-dependent, so they live beside this control struct in the top.
package cpa_pkg;

  localparam int DEFAULT_CHUNK = 4;

  typedef struct packed {
    logic vld;
    logic carry;
    logic msb_carry;
  } cpa_stage_t;

  function automatic int cpa_stages(input int width, input int chunk);
    return width / chunk;
  endfunction

endpackage

// File: rtl/cpa_chunk_adder.sv
// Combinational CHUNK-bit ripple adder; also exposes the carry into its top bit
// so the final stage can form signed overflow.
module cpa_chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             c_msb_in
);

  logic carry;

  always_comb begin
    carry    = cin;
    s        = '0;
    c_msb_in = 1'b0;
    for (int i = 0; i < CHUNK; i++) begin
      if (i == CHUNK - 1) c_msb_in = carry;
      s[i]  = x[i] ^ y[i] ^ carry;
      carry = (x[i] & y[i]) | (carry & (x[i] ^ y[i]));
    end
    cout = carry;
  end

endmodule

// File: rtl/pipelined_cpa.sv
// Pipelined WIDTH-bit adder/subtractor: one CHUNK-bit ripple slice per stage,
// valid/ready handshake with an elastic, combinational ready chain.
module pipelined_cpa
  import cpa_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = DEFAULT_CHUNK
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);

  localparam int STAGES = cpa_stages(WIDTH, CHUNK);

  if (WIDTH < 2) begin : g_bad_width
    $error("pipelined_cpa: WIDTH must be at least 2");
  end
  if (WIDTH % CHUNK != 0) begin : g_bad_chunk
    $error("pipelined_cpa: WIDTH must be a multiple of CHUNK");
  end

  cpa_stage_t       ctl   [STAGES];
  logic [WIDTH-1:0] psum  [STAGES];
  logic [WIDTH-1:0] opa   [STAGES];
  logic [WIDTH-1:0] opb   [STAGES];

  logic [WIDTH-1:0] nxt_sum [STAGES];
  logic [WIDTH-1:0] src_a   [STAGES];
  logic [WIDTH-1:0] src_b   [STAGES];
  logic [STAGES-1:0] src_vld, nxt_carry, nxt_msb, vld, can_load;

  logic [WIDTH-1:0] b_eff;
  assign b_eff = sub ? ~b : b;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [CHUNK-1:0] x, y, s;
    logic             cin, cout, cmsb;
    logic [WIDTH-1:0] prior;

    if (k == 0) begin : g_first
      assign x          = a[CHUNK-1:0];
      assign y          = b_eff[CHUNK-1:0];
      assign cin        = sub | c_in;
      assign prior      = '0;
      assign src_vld[k] = in_valid;
      assign src_a[k]   = a;
      assign src_b[k]   = b_eff;
    end else begin : g_next
      assign x          = opa[k-1][k*CHUNK +: CHUNK];
      assign y          = opb[k-1][k*CHUNK +: CHUNK];
      assign cin        = ctl[k-1].carry;
      assign prior      = psum[k-1];
      assign src_vld[k] = ctl[k-1].vld;
      assign src_a[k]   = opa[k-1];
      assign src_b[k]   = opb[k-1];
    end

    cpa_chunk_adder #(.CHUNK(CHUNK)) u_add (
      .x        (x),
      .y        (y),
      .cin      (cin),
      .s        (s),
      .cout     (cout),
      .c_msb_in (cmsb)
    );

    // Partial sums only ever hold zeros above the chunks already computed.
    assign nxt_sum[k]   = prior | (WIDTH'(s) << (k * CHUNK));
    assign nxt_carry[k] = cout;
    assign nxt_msb[k]   = cmsb;
    assign vld[k]       = ctl[k].vld;
    // A stage can load if the output drains or any slot at or after it is empty.
    assign can_load[k]  = out_ready || !(&vld[STAGES-1:k]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) begin
        ctl[k]  <= '0;
        psum[k] <= '0;
        opa[k]  <= '0;
        opb[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (can_load[k]) begin
          ctl[k].vld <= src_vld[k];
          if (src_vld[k]) begin
            psum[k]          <= nxt_sum[k];
            opa[k]           <= src_a[k];
            opb[k]           <= src_b[k];
            ctl[k].carry     <= nxt_carry[k];
            ctl[k].msb_carry <= nxt_msb[k];
          end
        end
      end
    end
  end

  // Output stage
  assign in_ready  = can_load[0] && !reset;
  assign out_valid = ctl[STAGES-1].vld;
  assign sum       = psum[STAGES-1];
  assign c_out     = ctl[STAGES-1].carry;
  assign overflow  = ctl[STAGES-1].carry ^ ctl[STAGES-1].msb_carry;

endmodule

// File: tb/tb_pipelined_cpa.sv
// Bench for pipelined_cpa (WIDTH=16, CHUNK=4): directed scenarios plus randomized
// traffic checked by an in-order scoreboard fed from an integer arithmetic model.
module tb_pipelined_cpa;

  localparam int WIDTH = 16;
  localparam int CHUNK = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid, in_ready;
  logic [WIDTH-1:0]  a, b;
  logic              c_in, sub;
  logic              out_valid, out_ready;
  logic [WIDTH-1:0]  sum;
  logic              c_out, overflow;

  always #5 clk = ~clk;

  pipelined_cpa #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .overflow  (overflow)
  );

  typedef struct {
    logic [WIDTH-1:0] s;
    logic             co;
    logic             ov;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic exp_t model(input logic [WIDTH-1:0] a_i, input logic [WIDTH-1:0] b_i,
                                 input logic cin_i, input logic sub_i);
    exp_t e;
    int   ua, ub, sa, sb, total, sres;
    ua = int'(a_i);
    ub = int'(b_i);
    sa = int'($signed(a_i));
    sb = int'($signed(b_i));
    if (sub_i) begin
      total = ua - ub;
      sres  = sa - sb;
      e.co  = (ua >= ub);
    end else begin
      total = ua + ub + int'(cin_i);
      sres  = sa + sb + int'(cin_i);
      e.co  = (total >= 65536);
    end
    e.s  = total[WIDTH-1:0];
    e.ov = (sres > 32767) || (sres < -32768);
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL sb_unexpected: got sum=%h c_out=%b with no pending op", sum, c_out);
        end else begin
          e = exp_q.pop_front();
          if (sum !== e.s || c_out !== e.co || overflow !== e.ov) begin
            n_err++;
            $display("FAIL sb_result: got sum=%h c=%b ov=%b, expected sum=%h c=%b ov=%b",
                     sum, c_out, overflow, e.s, e.co, e.ov);
          end
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(a, b, c_in, sub));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_one(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                           input logic cv, input logic sv);
    int t;
    a = av; b = bv; c_in = cv; sub = sv; in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 50) begin
      step();
      t++;
    end
    n_vec++;
    if (!in_ready) begin
      n_err++;
      $display("FAIL issue_timeout: in_ready=%b after %0d cycles, required 1", in_ready, t);
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic run_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                        input logic cv, input logic sv, output int lat,
                        output logic [WIDTH-1:0] s, output logic co, output logic ov);
    issue_one(av, bv, cv, sv);
    lat = 1;
    while (!out_valid && lat < 40) begin
      step();
      lat++;
    end
    s = sum; co = c_out; ov = overflow;
  endtask

  task automatic drain();
    int t;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    t = 0;
    while ((exp_q.size() != 0 || out_valid) && t < 60) begin
      step();
      t++;
    end
    n_vec++;
    if (exp_q.size() != 0 || out_valid) begin
      n_err++;
      $display("FAIL drain: %0d results outstanding, out_valid=%b, required 0", exp_q.size(), out_valid);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
    step();
    step();
    n_vec += 5;
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready: got %b, required 0", in_ready); end
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b, required 0", out_valid); end
    if (sum !== '0) begin n_err++; $display("FAIL rst_sum: got %h, required 0000", sum); end
    if (c_out !== 1'b0) begin n_err++; $display("FAIL rst_c_out: got %b, required 0", c_out); end
    if (overflow !== 1'b0) begin n_err++; $display("FAIL rst_overflow: got %b, required 0", overflow); end
    reset = 1'b0;
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_release_ready: got %b, required 1", in_ready); end
  endtask

  task automatic test_latency();
    int lat; logic [WIDTH-1:0] s; logic co, ov;
    run_op(16'd4, 16'd5, 1'b0, 1'b0, lat, s, co, ov);
    n_vec += 4;
    if (lat !== 4) begin n_err++; $display("FAIL lat_cycles: got %0d, required 4", lat); end
    if (s !== 16'd9) begin n_err++; $display("FAIL lat_sum: got %h, required 0009", s); end
    if (co !== 1'b0) begin n_err++; $display("FAIL lat_c_out: got %b, required 0", co); end
    if (ov !== 1'b0) begin n_err++; $display("FAIL lat_overflow: got %b, required 0", ov); end
  endtask

  task automatic test_carry_chain();
    int lat; logic [WIDTH-1:0] s; logic co, ov;
    run_op(16'hFFFF, 16'h0001, 1'b1, 1'b0, lat, s, co, ov);
    n_vec += 3;
    if (s !== 16'h0001) begin n_err++; $display("FAIL chain_sum: got %h, required 0001", s); end
    if (co !== 1'b1) begin n_err++; $display("FAIL chain_c_out: got %b, required 1", co); end
    if (ov !== 1'b0) begin n_err++; $display("FAIL chain_overflow: got %b, required 0", ov); end
  endtask

  task automatic test_sub();
    int lat; logic [WIDTH-1:0] s; logic co, ov;
    run_op(16'h0005, 16'h0007, 1'b1, 1'b1, lat, s, co, ov);
    n_vec += 3;
    if (s !== 16'hFFFE) begin n_err++; $display("FAIL sub1_sum: got %h, required fffe", s); end
    if (co !== 1'b0) begin n_err++; $display("FAIL sub1_c_out: got %b, required 0", co); end
    if (ov !== 1'b0) begin n_err++; $display("FAIL sub1_overflow: got %b, required 0", ov); end
    run_op(16'h8000, 16'h0001, 1'b1, 1'b1, lat, s, co, ov);
    n_vec += 3;
    if (s !== 16'h7FFF) begin n_err++; $display("FAIL sub2_sum: got %h, required 7fff", s); end
    if (co !== 1'b1) begin n_err++; $display("FAIL sub2_c_out: got %b, required 1", co); end
    if (ov !== 1'b1) begin n_err++; $display("FAIL sub2_overflow: got %b, required 1", ov); end
  endtask

  task automatic test_back_to_back();
    drain();
    for (int s = 0; s < 12; s++) begin
      if (s < 8) begin
        a = WIDTH'(s); b = WIDTH'(s); c_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
        n_vec++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready[%0d]: got %b, required 1", s, in_ready); end
      end else begin
        in_valid = 1'b0;
      end
      n_vec++;
      if (out_valid !== (s >= 4)) begin
        n_err++; $display("FAIL b2b_valid[%0d]: got %b, required %b", s, out_valid, (s >= 4));
      end
      if (s >= 4) begin
        n_vec++;
        if (sum !== WIDTH'(2 * (s - 4))) begin
          n_err++; $display("FAIL b2b_sum[%0d]: got %h, required %h", s, sum, WIDTH'(2 * (s - 4)));
        end
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    int accepted; logic [WIDTH-1:0] held;
    drain();
    out_ready = 1'b0;
    accepted  = 0;
    held      = '0;
    for (int s = 0; s < 8; s++) begin
      a = WIDTH'($urandom); b = WIDTH'($urandom); c_in = 1'($urandom); sub = 1'($urandom);
      in_valid = 1'b1;
      if (in_ready) accepted++;
      if (s == 4) begin
        held = sum;
        n_vec++;
        if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid: got %b, required 1", out_valid); end
      end else if (s > 4) begin
        n_vec++;
        if (sum !== held || out_valid !== 1'b1) begin
          n_err++; $display("FAIL bp_hold[%0d]: got sum=%h valid=%b, required sum=%h valid=1", s, sum, out_valid, held);
        end
      end
      step();
    end
    n_vec += 2;
    if (accepted !== 4) begin n_err++; $display("FAIL bp_accepted: got %0d, required 4", accepted); end
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_full_ready: got %b, required 0", in_ready); end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_ready: got %b, required 1", in_ready); end
    drain();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      a = WIDTH'($urandom); b = WIDTH'($urandom); c_in = 1'($urandom); sub = 1'($urandom);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    drain();
  endtask

  task automatic test_reset_midflight();
    int lat; logic [WIDTH-1:0] s; logic co, ov;
    drain();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a = WIDTH'(16'h1111 * (i + 1)); b = 16'h0101; c_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    step();
    n_vec++;
    if (out_valid !== 1'b1) begin n_err++; $display("FAIL mid_pre_valid: got %b, required 1", out_valid); end
    #2 reset = 1'b1;
    #1;
    n_vec += 4;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_async_valid: got %b, required 0", out_valid); end
    if (sum !== '0) begin n_err++; $display("FAIL mid_async_sum: got %h, required 0000", sum); end
    if (c_out !== 1'b0) begin n_err++; $display("FAIL mid_async_c_out: got %b, required 0", c_out); end
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL mid_async_ready: got %b, required 0", in_ready); end
    step();
    step();
    reset     = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_stale_valid: got %b, required 0", out_valid); end
    run_op(16'd1, 16'd2, 1'b0, 1'b0, lat, s, co, ov);
    n_vec += 2;
    if (lat !== 4) begin n_err++; $display("FAIL mid_lat: got %0d, required 4", lat); end
    if (s !== 16'd3) begin n_err++; $display("FAIL mid_sum: got %h, required 0003", s); end
    drain();
  endtask

  initial begin
    test_reset();
    test_latency();
    test_carry_chain();
    test_sub();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
